rf_scoreboard: RTL and testbench

RF_SCOREBOARD -- requirements
Module: rf_scoreboard

---
 rtl/rf_pkg.sv | 12 +
 rtl/rf_busy_table.sv | 50 +++++
 rtl/rf_scoreboard.sv | 69 ++++++
 tb/tb_rf_scoreboard.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared defaults, address type and zero-register constant for the register-file scoreboard.
package rf_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned NREG_DEF = 32;
  localparam int unsigned AW_DEF   = $clog2(NREG_DEF);

  typedef logic [AW_DEF-1:0] rf_addr_t;

  localparam rf_addr_t ZERO_REG = '0;

endpackage

// File: rtl/rf_busy_table.sv
// Per-register pending-producer bits with flush/set/clear priority and a population count.
module rf_busy_table
  import rf_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            rsv_en_i,
  input  logic [AW-1:0]   rsv_addr_i,
  input  logic            wr_en_i,
  input  logic [AW-1:0]   wr_addr_i,
  input  logic            flush_i,
  output logic [NREG-1:0] busy_o,
  output logic [AW:0]     busy_cnt_o
);

  localparam int unsigned CW = AW + 1;

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;

  // Flush wins over everything; a reserve beats a same-address writeback.
  always_comb begin
    w_busy_nxt = r_busy;
    if (flush_i) begin
      w_busy_nxt = '0;
    end else begin
      if (wr_en_i) w_busy_nxt[wr_addr_i] = 1'b0;
      if (rsv_en_i) w_busy_nxt[rsv_addr_i] = 1'b1;
    end
    w_busy_nxt[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) r_busy <= '0;
    else          r_busy <= w_busy_nxt;
  end

  always_comb begin
    busy_cnt_o = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      busy_cnt_o = busy_cnt_o + CW'(r_busy[i]);
    end
  end

  assign busy_o = r_busy;

endmodule

// File: rtl/rf_scoreboard.sv
// Register file with combinational multi-port read, optional write bypass, and busy tracking.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned XLEN      = XLEN_DEF,
  parameter int unsigned NREG      = NREG_DEF,
  parameter int unsigned NRD       = 2,
  parameter int unsigned WR_BYPASS = 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NRD*$clog2(NREG)-1:0] rs_addr_i,
  output logic [NRD*XLEN-1:0]       rs_data_o,
  output logic [NRD-1:0]            rs_busy_o,
  input  logic                      wr_en_i,
  input  logic [$clog2(NREG)-1:0]   wr_addr_i,
  input  logic [XLEN-1:0]           wr_data_i,
  input  logic                      rsv_en_i,
  input  logic [$clog2(NREG)-1:0]   rsv_addr_i,
  input  logic                      flush_i,
  output logic [$clog2(NREG):0]     busy_cnt_o
);

  localparam int unsigned AW = $clog2(NREG);

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] w_busy;
  logic            w_wr_nz;

  assign w_wr_nz = wr_en_i && (wr_addr_i != AW'(ZERO_REG));

  rf_busy_table #(
    .NREG (NREG),
    .AW   (AW)
  ) u_busy (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .rsv_en_i   (rsv_en_i),
    .rsv_addr_i (rsv_addr_i),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .flush_i    (flush_i),
    .busy_o     (w_busy),
    .busy_cnt_o (busy_cnt_o)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      for (int i = 0; i < int'(NREG); i++) r_regs[i] <= '0;
    end else if (w_wr_nz) begin
      r_regs[wr_addr_i] <= wr_data_i;
    end
  end

  // Each read port: register 0 reads as zero; a same-cycle writeback may forward.
  for (genvar k = 0; k < int'(NRD); k++) begin : g_rd
    logic [AW-1:0] w_a;
    logic          w_nz;
    logic          w_hit;

    assign w_a   = rs_addr_i[k*AW +: AW];
    assign w_nz  = (w_a != AW'(ZERO_REG));
    assign w_hit = (WR_BYPASS != 0) && w_wr_nz && (wr_addr_i == w_a);

    assign rs_data_o[k*XLEN +: XLEN] = w_hit ? wr_data_i : (w_nz ? r_regs[w_a] : '0);
    assign rs_busy_o[k]              = w_nz && !w_hit && w_busy[w_a];
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Randomized and directed bench for rf_scoreboard; a queue-based scoreboard compares against a reference model.
module tb_rf_scoreboard;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NRD  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset_i;
  logic [NRD*AW-1:0]    rs_addr_i;
  logic                 wr_en_i;
  logic [AW-1:0]        wr_addr_i;
  logic [XLEN-1:0]      wr_data_i;
  logic                 rsv_en_i;
  logic [AW-1:0]        rsv_addr_i;
  logic                 flush_i;

  logic [NRD*XLEN-1:0]  data_b, data_n;
  logic [NRD-1:0]       busy_b, busy_n;
  logic [AW:0]          cnt_b, cnt_n;

  rf_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .WR_BYPASS(1)) u_dut (
    .clk_i(clk), .reset_i(reset_i), .rs_addr_i(rs_addr_i), .rs_data_o(data_b),
    .rs_busy_o(busy_b), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .rsv_en_i(rsv_en_i), .rsv_addr_i(rsv_addr_i), .flush_i(flush_i), .busy_cnt_o(cnt_b)
  );

  rf_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .WR_BYPASS(0)) u_dut_nb (
    .clk_i(clk), .reset_i(reset_i), .rs_addr_i(rs_addr_i), .rs_data_o(data_n),
    .rs_busy_o(busy_n), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .rsv_en_i(rsv_en_i), .rsv_addr_i(rsv_addr_i), .flush_i(flush_i), .busy_cnt_o(cnt_n)
  );

  typedef struct {
    int          cyc;
    logic [63:0] d_b;
    logic [1:0]  b_b;
    logic [63:0] d_n;
    logic [1:0]  b_n;
    logic [5:0]  cnt;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc_no   = 0;

  // Architectural reference state.
  logic [31:0] m_mem [32];
  bit          m_bsy [32];

  task automatic check(input string nm, input int cyc, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, expv);
    end
  endtask

  // Monitor: outputs are stable by the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("rs_data_bypass", e.cyc, 64'(data_b), e.d_b);
      check("rs_busy_bypass", e.cyc, 64'(busy_b), 64'(e.b_b));
      check("rs_data_nobypass", e.cyc, 64'(data_n), e.d_n);
      check("rs_busy_nobypass", e.cyc, 64'(busy_n), 64'(e.b_n));
      check("busy_cnt_bypass", e.cyc, 64'(cnt_b), 64'(e.cnt));
      check("busy_cnt_nobypass", e.cyc, 64'(cnt_n), 64'(e.cnt));
    end
  end

  task automatic cycle(input bit rst, input bit we, input int wa, input logic [31:0] wd,
                       input bit re, input int ra, input bit fl, input int a0, input int a1,
                       input bit chk);
    exp_t e;
    int   a;
    int   cnt;
    reset_i    = ~rst;
    wr_en_i    = we;
    wr_addr_i  = AW'(wa);
    wr_data_i  = wd;
    rsv_en_i   = re;
    rsv_addr_i = AW'(ra);
    flush_i    = fl;
    rs_addr_i  = {AW'(a1), AW'(a0)};

    e.cyc = cyc_no;
    cnt = 0;
    for (int r = 0; r < 32; r++) if (m_bsy[r]) cnt++;
    e.cnt = 6'(cnt);
    e.d_b = '0; e.d_n = '0; e.b_b = '0; e.b_n = '0;
    for (int k = 0; k < 2; k++) begin
      logic [31:0] dv;
      bit          bv;
      a  = (k == 0) ? a0 : a1;
      dv = (a == 0) ? 32'h0 : m_mem[a];
      bv = (a == 0) ? 1'b0 : m_bsy[a];
      e.d_n[k*32 +: 32] = dv;
      e.b_n[k] = bv;
      if (we && a != 0 && a == wa) begin
        dv = wd;
        bv = 1'b0;
      end
      e.d_b[k*32 +: 32] = dv;
      e.b_b[k] = bv;
    end
    if (chk) exp_q.push_back(e);

    @(posedge clk);
    #1;
    cyc_no++;

    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        m_mem[r] = '0;
        m_bsy[r] = 1'b0;
      end
    end else begin
      if (we && wa != 0) m_mem[wa] = wd;
      if (fl) begin
        for (int r = 0; r < 32; r++) m_bsy[r] = 1'b0;
      end else begin
        if (we && wa != 0) m_bsy[wa] = 1'b0;
        if (re && ra != 0) m_bsy[ra] = 1'b1;
      end
    end
  endtask

  task automatic rd(input int a0, input int a1);
    cycle(0, 0, 0, 32'h0, 0, 0, 0, a0, a1, 1);
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin
      m_mem[r] = '0;
      m_bsy[r] = 1'b0;
    end

    cycle(1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 32'h0, 0, 0, 0, 5, 1, 1);
    rd(5, 31);

    // Reset clears a written register.
    cycle(0, 1, 5, 32'hDEADBEEF, 1, 6, 0, 5, 5, 1);
    rd(5, 6);
    cycle(1, 0, 0, 32'h0, 1, 8, 0, 5, 6, 1);
    rd(5, 6);

    // Same-cycle forwarding on port 1.
    cycle(0, 1, 7, 32'h12345678, 0, 0, 0, 5, 7, 1);
    rd(7, 7);

    // Reserve, clear by writeback, flush.
    cycle(0, 0, 0, 32'h0, 1, 3, 0, 3, 4, 1);
    cycle(0, 0, 0, 32'h0, 1, 4, 0, 3, 4, 1);
    rd(3, 4);
    cycle(0, 1, 3, 32'h00000033, 0, 0, 0, 3, 4, 1);
    rd(3, 4);
    cycle(0, 0, 0, 32'h0, 0, 0, 1, 3, 4, 1);
    rd(3, 4);

    // Reserve and write the same register together.
    cycle(0, 1, 9, 32'h000000A5, 1, 9, 0, 9, 0, 1);
    rd(9, 9);
    cycle(0, 0, 0, 32'h0, 1, 9, 0, 9, 1, 1);
    rd(9, 0);

    // Register 0 ignores write and reserve.
    cycle(0, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 9, 1);
    rd(0, 0);

    // Flush overrides a same-cycle reserve.
    cycle(0, 0, 0, 32'h0, 1, 3, 0, 3, 12, 1);
    cycle(0, 1, 12, 32'hCAFE0012, 1, 12, 1, 12, 3, 1);
    rd(12, 3);

    for (int i = 0; i < 3000; i++) begin
      bit rst, we, re, fl;
      int wa, ra, a0, a1;
      rst = ($urandom_range(0, 63) == 0);
      we  = $urandom_range(0, 1) == 1;
      re  = $urandom_range(0, 1) == 1;
      fl  = ($urandom_range(0, 15) == 0);
      wa  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
      a0  = ($urandom_range(0, 1) == 0) ? wa : int'($urandom_range(0, 7));
      a1  = ($urandom_range(0, 2) == 0) ? a0 : int'($urandom_range(0, 31));
      cycle(rst, we, wa, $urandom, re, ra, fl, a0, a1, 1);
    end

    rd(0, 0);
    for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_errors++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
